// File: rtl/jvm_fetch_pkg.sv
// Shared definitions for the JVM bytecode prefetch stage: fetch FSM
// encoding, decoder window size and consume-port width.
package jvm_fetch_pkg;

    // Fetch handshake states. ISSUED exists because the memory only drops
    // ready the cycle after it samples start, so ready is not meaningful there.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUED = 2'd1,
        ST_WAIT   = 2'd2
    } fetch_state_e;

    // Bytes presented to the decoder: opcode plus two operand bytes.
    localparam int WIN_BYTES = 3;
    localparam int WIN_W     = WIN_BYTES * 8;

    // Width of the consume request (0..3 bytes per cycle).
    localparam int CONSUME_W = 2;

    // Number of bytes actually removed: the request, limited to what is held.
    function automatic logic [CONSUME_W-1:0] clamp_pop(
        input logic [CONSUME_W-1:0] req,
        input int unsigned          avail
    );
        logic [CONSUME_W-1:0] n;
        if (32'(req) > avail) begin
            n = CONSUME_W'(avail);
        end else begin
            n = req;
        end
        return n;
    endfunction

endpackage

// File: rtl/jvm_bytecode_fetch_queue.sv
// Circular byte buffer between the memory handshake and the decoder.
// One byte may enter per cycle; 0..3 bytes may leave per cycle; a flush
// empties it. The head three bytes are presented as a little-endian window,
// with positions beyond the fill level forced to zero.
module fetch_byte_queue
    import jvm_fetch_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    input  logic                 push,
    input  logic [7:0]           push_data,
    input  logic [CONSUME_W-1:0] pop_n,
    output logic [CNT_W-1:0]     count,
    output logic [WIN_W-1:0]     window
);

    logic [7:0]       store_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    // Pointer and fill-level bookkeeping; a flush discards everything held.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_q <= wr_ptr_q;
            end
            rd_ptr_q <= rd_ptr_q + PTR_W'(pop_n);
            count_q  <= count_q + CNT_W'(push) - CNT_W'(pop_n);
        end
    end

    // Byte storage; cleared on reset so stale data never reaches the window.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                store_q[i] <= 8'h00;
            end
        end else if (push && !flush) begin
            store_q[wr_ptr_q] <= push_data;
        end else begin
            store_q[wr_ptr_q] <= store_q[wr_ptr_q];
        end
    end

    // Head window: byte i is valid only while i is below the fill level.
    always_comb begin
        logic [PTR_W-1:0] idx;
        window = '0;
        idx    = '0;
        for (int i = 0; i < WIN_BYTES; i++) begin
            idx = rd_ptr_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                window[i*8 +: 8] = store_q[idx];
            end else begin
                window[i*8 +: 8] = 8'h00;
            end
        end
    end

    assign count = count_q;

endmodule

// File: rtl/jvm_bytecode_fetch.sv
// Bytecode prefetch stage. Walks fetch_pc through a byte-wide memory one
// request at a time, buffers the returned bytes and hands the decoder a
// 3-byte window with the PC of its first byte. A redirect flushes the buffer
// and, if a request is in flight, marks its response to be dropped.
module jvm_bytecode_fetch
    import jvm_fetch_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 8,
    parameter int                       DEPTH         = 4,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     mem_start,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    input  logic                     mem_ready,
    input  logic [7:0]               mem_data,
    input  logic                     redirect_valid,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    input  logic [CONSUME_W-1:0]     consume,
    output logic [WIN_W-1:0]         win_bytes,
    output logic [$clog2(DEPTH):0]   q_count,
    output logic [ADDRESS_WIDTH-1:0] pc_out,
    output logic                     err
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_e             state_q;
    logic [ADDRESS_WIDTH-1:0] fetch_pc_q;
    logic [ADDRESS_WIDTH-1:0] pc_out_q;
    logic [ADDRESS_WIDTH-1:0] mem_address_q;
    logic                     mem_start_q;
    logic                     discard_q;
    logic                     err_q;

    logic                     push_s;
    logic [CONSUME_W-1:0]     pop_n_s;
    logic                     over_s;
    logic [CNT_W-1:0]         count_s;

    // Per-cycle queue actions; a redirect suppresses both push and pop.
    always_comb begin
        push_s  = 1'b0;
        pop_n_s = '0;
        over_s  = 1'b0;
        if (redirect_valid) begin
            push_s  = 1'b0;
            pop_n_s = '0;
            over_s  = 1'b0;
        end else begin
            push_s  = (state_q == ST_WAIT) && mem_ready && !discard_q;
            pop_n_s = clamp_pop(consume, 32'(count_s));
            over_s  = (32'(consume) > 32'(count_s));
        end
    end

    fetch_byte_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .flush     (redirect_valid),
        .push      (push_s),
        .push_data (mem_data),
        .pop_n     (pop_n_s),
        .count     (count_s),
        .window    (win_bytes)
    );

    // Fetch FSM with its registered handshake outputs, PCs, discard and err.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            fetch_pc_q    <= RESET_PC;
            pc_out_q      <= RESET_PC;
            mem_start_q   <= 1'b0;
            mem_address_q <= '0;
            discard_q     <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            mem_start_q <= 1'b0;

            if (over_s) begin
                err_q <= 1'b1;
            end else begin
                err_q <= err_q;
            end

            if (redirect_valid) begin
                pc_out_q <= redirect_pc;
            end else begin
                pc_out_q <= pc_out_q + ADDRESS_WIDTH'(pop_n_s);
            end

            case (state_q)
                ST_IDLE: begin
                    // Leaving IDLE needs ready high, which also guarantees a
                    // response left over from before a reset has drained.
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_pc;
                    end else if (mem_ready && (count_s < CNT_W'(DEPTH))) begin
                        mem_start_q   <= 1'b1;
                        mem_address_q <= fetch_pc_q;
                        state_q       <= ST_ISSUED;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_ISSUED: begin
                    state_q <= ST_WAIT;
                    if (redirect_valid) begin
                        fetch_pc_q <= redirect_pc;
                        discard_q  <= 1'b1;
                    end else begin
                        discard_q <= discard_q;
                    end
                end
                ST_WAIT: begin
                    if (mem_ready) begin
                        // The response is consumed here whatever happens; a
                        // redirect arriving with it drops it outright, so no
                        // discard needs to carry over to the next request.
                        state_q   <= ST_IDLE;
                        discard_q <= 1'b0;
                        if (redirect_valid) begin
                            fetch_pc_q <= redirect_pc;
                        end else if (!discard_q) begin
                            fetch_pc_q <= fetch_pc_q + ADDRESS_WIDTH'(1);
                        end else begin
                            fetch_pc_q <= fetch_pc_q;
                        end
                    end else if (redirect_valid) begin
                        fetch_pc_q <= redirect_pc;
                        discard_q  <= 1'b1;
                    end else begin
                        state_q <= ST_WAIT;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_start   = mem_start_q;
    assign mem_address = mem_address_q;
    assign q_count     = count_s;
    assign pc_out      = pc_out_q;
    assign err         = err_q;

endmodule

// File: tb/tb_jvm_bytecode_fetch.sv
// Bench for jvm_bytecode_fetch: a byte-memory model, a queue-level reference
// model compared every cycle, and directed scenarios with literal expectations.
module tb_jvm_bytecode_fetch;

    localparam int AW    = 8;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mem_start;
    logic [AW-1:0] mem_address;
    logic          mem_ready = 1'b1;
    logic [7:0]    mem_data = 8'h00;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = 8'h00;
    logic [1:0]    consume = 2'd0;
    logic [23:0]   win_bytes;
    logic [2:0]    q_count;
    logic [AW-1:0] pc_out;
    logic          err;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jvm_bytecode_fetch #(
        .ADDRESS_WIDTH (AW),
        .DEPTH         (DEPTH),
        .RESET_PC      (8'h00)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mem_start      (mem_start),
        .mem_address    (mem_address),
        .mem_ready      (mem_ready),
        .mem_data       (mem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .consume        (consume),
        .win_bytes      (win_bytes),
        .q_count        (q_count),
        .pc_out         (pc_out),
        .err            (err)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- memory model and reference model ----------------
    logic [7:0] marr [256];
    logic [7:0] mq [$];
    logic [AW-1:0] m_pc, m_fpc;
    bit m_err, m_keep, model_on, resp_pend, busy, deliver;
    int cnt, n;

    function automatic logic [23:0] model_win();
        logic [23:0] w;
        w = 24'h0;
        for (int i = 0; i < 3; i++) begin
            if (i < mq.size()) w[i*8 +: 8] = mq[i];
        end
        return w;
    endfunction

    initial begin
        for (int i = 0; i < 256; i++) marr[i] = 8'(i);
        forever begin
            @(posedge clk);
            // memory: busy for 1+addr[1:0] cycles after sampling start
            deliver = resp_pend && (mem_ready === 1'b1);
            if (deliver) resp_pend = 1'b0;
            if (mem_start === 1'b1) begin
                mem_ready <= 1'b0;
                mem_data  <= marr[mem_address];
                cnt       = int'(mem_address[1:0]);
                resp_pend = 1'b1;
                busy      = 1'b1;
            end else if (busy) begin
                if (cnt == 0) begin
                    mem_ready <= 1'b1;
                    busy      = 1'b0;
                end else begin
                    cnt--;
                end
            end
            // reference: byte queue with PCs, driven by the rules of the stage
            if (reset === 1'b1) begin
                mq.delete();
                m_pc     = 8'h00;
                m_fpc    = 8'h00;
                m_err    = 1'b0;
                m_keep   = 1'b0;
                model_on = 1'b1;
            end else begin
                if (redirect_valid) begin
                    mq.delete();
                    m_pc   = redirect_pc;
                    m_fpc  = redirect_pc;
                    m_keep = 1'b0;
                end else begin
                    n = (int'(consume) > mq.size()) ? mq.size() : int'(consume);
                    if (int'(consume) > mq.size()) m_err = 1'b1;
                    repeat (n) void'(mq.pop_front());
                    m_pc = m_pc + 8'(n);
                    if (deliver && m_keep) begin
                        mq.push_back(mem_data);
                        m_fpc = m_fpc + 8'd1;
                    end
                    if (deliver) m_keep = 1'b0;
                end
                if (mem_start === 1'b1) m_keep = !redirect_valid;
            end
        end
    end

    // Per-cycle comparison of every output against the reference model.
    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                chk("cmp_q_count", q_count, mq.size());
                chk("cmp_win_bytes", win_bytes, model_win());
                chk("cmp_pc_out", pc_out, m_pc);
                chk("cmp_err", err, m_err);
                if (mem_start === 1'b1) chk("cmp_mem_address", mem_address, m_fpc);
            end
        end
    end

    // ---------------- directed scenarios ----------------
    task automatic wait_start(input string nm, input logic [7:0] exp_addr);
        int k;
        k = 0;
        @(negedge clk);
        while (mem_start !== 1'b1 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_seen"}, mem_start, 1);
        chk(nm, mem_address, exp_addr);
    endtask

    task automatic wait_nonempty(input string nm);
        int k;
        k = 0;
        while (q_count == 3'd0 && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk({nm, "_nonempty"}, (q_count != 3'd0), 1);
    endtask

    task automatic do_reset();
        reset = 1'b1; consume = 2'd0; redirect_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_q"}, q_count, 0);
        chk({nm, "_pc"}, pc_out, 8'h00);
        chk({nm, "_err"}, err, 0);
        chk({nm, "_win"}, win_bytes, 24'h0);
        chk({nm, "_start"}, mem_start, 0);
        chk({nm, "_addr"}, mem_address, 8'h00);
    endtask

    initial begin
        int k, starts;
        // 1: fill from reset
        reset = 1'b1;
        @(negedge clk); @(negedge clk);
        chk_reset_vals("t1_rst");
        reset = 1'b0;
        wait_start("t1_addr0", 8'h00);
        k = 0;
        while (q_count == 3'd0 && k < 20) begin @(negedge clk); k++; end
        chk("t1_latency", k, 3);
        wait_start("t1_addr1", 8'h01);
        wait_start("t1_addr2", 8'h02);
        wait_start("t1_addr3", 8'h03);
        k = 0;
        while (q_count != 3'd4 && k < 30) begin @(negedge clk); k++; end
        starts = 0;
        for (int i = 0; i < 10; i++) begin
            if (mem_start === 1'b1) starts++;
            @(negedge clk);
        end
        chk("t1_no_issue_full", starts, 0);
        chk("t1_q", q_count, 4);
        chk("t1_win", win_bytes, 24'h020100);
        chk("t1_pc", pc_out, 8'h00);

        // 2: consume three from a full queue
        consume = 2'd3;
        @(negedge clk);
        consume = 2'd0;
        chk("t2_q", q_count, 1);
        chk("t2_pc", pc_out, 8'h03);
        chk("t2_b0", win_bytes[7:0], 8'h03);
        wait_start("t2_addr4", 8'h04);
        repeat (3) @(negedge clk);
        chk("t2_q2", q_count, 2);
        chk("t2_win2", win_bytes, 24'h000403);

        // 3: redirect while waiting on address 2
        do_reset();
        wait_start("t3_addr0", 8'h00);
        wait_start("t3_addr1", 8'h01);
        wait_start("t3_addr2", 8'h02);
        @(negedge clk);
        redirect_valid = 1'b1; redirect_pc = 8'h40;
        @(negedge clk);
        redirect_valid = 1'b0;
        chk("t3_q_flush", q_count, 0);
        chk("t3_pc", pc_out, 8'h40);
        wait_start("t3_addr40", 8'h40);
        wait_nonempty("t3");
        chk("t3_q1", q_count, 1);
        chk("t3_b0", win_bytes[7:0], 8'h40);
        chk("t3_pc2", pc_out, 8'h40);

        // 4: push and consume=1 in the same cycle at q_count=2
        wait_start("t4_addr41", 8'h41);
        wait_start("t4_addr42", 8'h42);
        repeat (4) @(negedge clk);
        chk("t4_q_before", q_count, 2);
        consume = 2'd1;
        @(negedge clk);
        consume = 2'd0;
        chk("t4_q", q_count, 2);
        chk("t4_pc", pc_out, 8'h41);
        chk("t4_win", win_bytes, 24'h004241);

        // 5: over-consume sets sticky err
        consume = 2'd1;
        @(negedge clk);
        chk("t5_q1", q_count, 1);
        consume = 2'd3;
        @(negedge clk);
        consume = 2'd0;
        chk("t5_q0", q_count, 0);
        chk("t5_pc", pc_out, 8'h43);
        chk("t5_err", err, 1);
        repeat (12) @(negedge clk);
        chk("t5_err_sticky", err, 1);

        // 6: reset during WAIT on address 3, memory still busy afterwards
        do_reset();
        chk("t6_err_cleared", err, 0);
        wait_start("t6_addr0", 8'h00);
        wait_start("t6_addr1", 8'h01);
        wait_start("t6_addr2", 8'h02);
        wait_start("t6_addr3", 8'h03);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals("t6_rst");
        reset = 1'b0;
        k = 0; starts = 0;
        while (mem_ready !== 1'b1 && k < 20) begin
            if (mem_start === 1'b1) starts++;
            @(negedge clk);
            k++;
        end
        chk("t6_no_start_busy", starts, 0);
        wait_start("t6_addr_after", 8'h00);
        wait_nonempty("t6");
        chk("t6_q1", q_count, 1);
        chk("t6_b0", win_bytes[7:0], 8'h00);
        chk("t6_pc", pc_out, 8'h00);

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
